// File: rtl/mul_tree_bf16_param.sv
// Pipelined bf16 product tree: N_IN leaves, group size 2^mode, one product per group on lanes 0..(N_IN>>mode)-1.
// Define MUL_TREE_STATUS_EN to add sticky {invalid, overflow, underflow, inexact} flags with status/status_clr ports.
module mul_tree_bf16_param #(
    parameter int N_IN  = 8,
    parameter int DW    = 16,
    parameter int LOG2N = $clog2(N_IN),
    parameter int MW    = $clog2(LOG2N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN*DW-1:0]   mul_ins,
    input  logic                 mul_stb,
    input  logic [MW-1:0]        mode,
    output logic [N_IN*DW-1:0]   outputs,
    output logic [N_IN-1:0]      final_output_stbs_1
`ifdef MUL_TREE_STATUS_EN
    ,
    output logic [3:0]           status,
    input  logic                 status_clr
`endif
);

    // bf16 multiply with DAZ inputs, FTZ results and round-to-nearest-even.
    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic               sgn;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [15:0]        prod;
        logic [7:0]         sig;
        logic               guard, sticky;
        logic [8:0]         sig_r;
        logic signed [10:0] exp_s;
        logic [15:0]        res;
        sgn    = a[15] ^ b[15];
        a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
        b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
        a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
        b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
        a_zero = (a[14:7] == 8'h00);
        b_zero = (b[14:7] == 8'h00);
        prod   = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
        exp_s  = $signed({3'b000, a[14:7]}) + $signed({3'b000, b[14:7]}) - 11'sd127;
        if (prod[15]) begin
            sig    = prod[15:8];
            guard  = prod[7];
            sticky = |prod[6:0];
            exp_s  = exp_s + 11'sd1;
        end else begin
            sig    = prod[14:7];
            guard  = prod[6];
            sticky = |prod[5:0];
        end
        sig_r = {1'b0, sig} + {8'h00, guard & (sticky | sig[0])};
        if (sig_r[8]) begin
            sig   = 8'h80;
            exp_s = exp_s + 11'sd1;
        end else begin
            sig = sig_r[7:0];
        end
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero))
            res = 16'h7FC0;
        else if (a_inf | b_inf)
            res = {sgn, 8'hFF, 7'h00};
        else if (a_zero | b_zero)
            res = {sgn, 15'h0000};
        else if (exp_s >= 11'sd255)
            res = {sgn, 8'hFF, 7'h00};
        else if (exp_s <= 11'sd0)
            res = {sgn, 15'h0000};
        else
            res = {sgn, exp_s[7:0], sig[6:0]};
        return res;
    endfunction

    // Level 0 is the input capture; level k+1 is computed combinationally from level k.
    logic [DW-1:0]    lane_q [LOG2N][N_IN];
    logic [DW-1:0]    lane_d [LOG2N][N_IN];
    logic [MW-1:0]    mode_q [LOG2N];
    logic [LOG2N-1:0] vld_q;

    always_comb begin
        for (int k = 0; k < LOG2N; k++) begin
            for (int j = 0; j < N_IN; j++) lane_d[k][j] = lane_q[k][j];
            if (k < int'(mode_q[k])) begin
                for (int j = 0; j < N_IN; j++) lane_d[k][j] = '0;
                for (int j = 0; j < (N_IN >> (k + 1)); j++)
                    lane_d[k][j] = bf16_mul(lane_q[k][2*j], lane_q[k][2*j+1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q               <= '0;
            outputs             <= '0;
            final_output_stbs_1 <= '0;
        end else begin
            vld_q[0] <= mul_stb;
            if (mul_stb) begin
                for (int j = 0; j < N_IN; j++) lane_q[0][j] <= mul_ins[j*DW +: DW];
                mode_q[0] <= (mode > MW'(LOG2N)) ? MW'(LOG2N) : mode;
            end
            for (int k = 1; k < LOG2N; k++) begin
                vld_q[k]  <= vld_q[k-1];
                lane_q[k] <= lane_d[k-1];
                mode_q[k] <= mode_q[k-1];
            end
            final_output_stbs_1 <= '0;
            if (vld_q[LOG2N-1]) begin
                for (int g = 0; g < N_IN; g++) begin
                    if (g < (N_IN >> mode_q[LOG2N-1])) begin
                        outputs[g*DW +: DW]    <= lane_d[LOG2N-1][g];
                        final_output_stbs_1[g] <= 1'b1;
                    end else begin
                        outputs[g*DW +: DW]    <= '0;
                    end
                end
            end
        end
    end

`ifdef MUL_TREE_STATUS_EN
    // Flags derive from input classes and the rounded result, so they track bf16_mul exactly.
    function automatic logic [3:0] bf16_flags(input logic [15:0] a, input logic [15:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, fin_nz, lost;
        logic [15:0] prod;
        logic [15:0] res;
        logic [3:0]  flg;
        a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
        b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
        a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
        b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
        a_zero = (a[14:7] == 8'h00);
        b_zero = (b[14:7] == 8'h00);
        fin_nz = !(a_nan | b_nan | a_inf | b_inf | a_zero | b_zero);
        prod   = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
        lost   = prod[15] ? (|prod[7:0]) : (|prod[6:0]);
        res    = bf16_mul(a, b);
        flg[3] = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        flg[2] = fin_nz && ((res & 16'h7FFF) == 16'h7F80);
        flg[1] = fin_nz && ((res & 16'h7FFF) == 16'h0000);
        flg[0] = fin_nz && lost;
        return flg;
    endfunction

    logic [3:0] flag_evt;

    always_comb begin
        flag_evt = '0;
        for (int k = 0; k < LOG2N; k++) begin
            if (vld_q[k] && (k < int'(mode_q[k]))) begin
                for (int j = 0; j < (N_IN >> (k + 1)); j++)
                    flag_evt = flag_evt | bf16_flags(lane_q[k][2*j], lane_q[k][2*j+1]);
            end
        end
    end

    // A clear and a new event in the same cycle leave the flag set.
    always_ff @(posedge clk) begin
        if (rst) status <= '0;
        else     status <= (status_clr ? 4'h0 : status) | flag_evt;
    end
`endif

endmodule

// File: tb/tb_mul_tree_bf16_param.sv
// Bench for mul_tree_bf16_param (N_IN=16): real-arithmetic bf16 model, scoreboard checked every cycle.
module tb_mul_tree_bf16_param;
    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int MW    = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*16-1:0] mul_ins = '0;
    logic            mul_stb = 1'b0;
    logic [MW-1:0]   mode = '0;
    logic [N*16-1:0] outputs;
    logic [N-1:0]    stbs;
`ifdef MUL_TREE_STATUS_EN
    logic [3:0]      status;
    logic            status_clr = 1'b0;
`endif

    mul_tree_bf16_param #(.N_IN(N)) dut (
        .clk(clk),
        .rst(rst),
        .mul_ins(mul_ins),
        .mul_stb(mul_stb),
        .mode(mode),
        .outputs(outputs),
        .final_output_stbs_1(stbs)
`ifdef MUL_TREE_STATUS_EN
        ,
        .status(status),
        .status_clr(status_clr)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic rst_q = 1'b1;

    typedef struct {
        int              due;
        logic [N*16-1:0] res;
        logic [N-1:0]    stb;
    } exp_t;
    exp_t exp_q[$];
    logic [N*16-1:0] held = '0;
    logic [N-1:0]    want_stb = '0;

    // Reference bf16 product in real arithmetic: returns {invalid, overflow, underflow, inexact, result}.
    function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int   ea = int'(a[14:7]);
        int   eb = int'(b[14:7]);
        int   fa = int'(a[6:0]);
        int   fb = int'(b[6:0]);
        logic s  = a[15] ^ b[15];
        bit   a_nan = (ea == 255) && (fa != 0);
        bit   b_nan = (eb == 255) && (fb != 0);
        bit   a_inf = (ea == 255) && (fa == 0);
        bit   b_inf = (eb == 255) && (fb == 0);
        bit   a_zero = (ea == 0);
        bit   b_zero = (eb == 0);
        real  m, sc, rem;
        int   e, q, be;
        logic inx;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {4'b1000, 16'h7FC0};
        if (a_inf || b_inf) return {4'b0000, s, 15'h7F80};
        if (a_zero || b_zero) return {4'b0000, s, 15'h0000};
        m = (1.0 + fa / 128.0) * (1.0 + fb / 128.0);
        e = (ea - 127) + (eb - 127);
        if (m >= 2.0) begin
            m = m / 2.0;
            e++;
        end
        sc  = m * 128.0;
        q   = $rtoi(sc);
        rem = sc - q;
        inx = (rem != 0.0);
        if (rem > 0.5 || (rem == 0.5 && (q % 2) == 1)) q++;
        if (q == 256) begin
            q = 128;
            e++;
        end
        be = e + 127;
        if (be >= 255) return {3'b010, inx, s, 15'h7F80};
        if (be <= 0)   return {3'b001, inx, s, 15'h0000};
        return {3'b000, inx, s, be[7:0], q[6:0]};
    endfunction

    function automatic void tree_model(input logic [N*16-1:0] ops, input int m,
                                       output logic [N*16-1:0] res, output logic [N-1:0] stb,
                                       output logic [3:0] fl);
        logic [15:0] v [N];
        logic [19:0] t;
        for (int i = 0; i < N; i++) v[i] = ops[i*16 +: 16];
        fl = '0;
        for (int k = 1; k <= m; k++)
            for (int j = 0; j < (N >> k); j++) begin
                t    = ref_mul(v[2*j], v[2*j+1]);
                v[j] = t[15:0];
                fl   = fl | t[19:16];
            end
        res = '0;
        stb = '0;
        for (int g = 0; g < (N >> m); g++) begin
            res[g*16 +: 16] = v[g];
            stb[g] = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic send(input logic [N*16-1:0] ops, input int m, input logic s);
        exp_t e;
        logic [3:0] fl;
        int mc;
        mul_ins = ops;
        mode    = m[MW-1:0];
        mul_stb = s;
        if (s) begin
            mc = (m > LOG2N) ? LOG2N : m;
            tree_model(ops, mc, e.res, e.stb, fl);
            e.due = cyc + 1 + LOG2N;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        mul_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Every cycle: outputs must equal the last completed result, strobes only on completion.
    always @(negedge clk) begin
        if (rst_q) begin
            while (exp_q.size() > 0 && (exp_q[0].due - LOG2N) <= cyc) void'(exp_q.pop_front());
            held     = '0;
            want_stb = '0;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            held     = exp_q[0].res;
            want_stb = exp_q[0].stb;
            void'(exp_q.pop_front());
        end else begin
            want_stb = '0;
        end
        n_tests++;
        if (outputs !== held || stbs !== want_stb) begin
            n_fail++;
            $display("FAIL out_chk cyc=%0d stbs got %h want %h lanes got %h want %h",
                     cyc, stbs, want_stb, outputs, held);
        end
    end

    function automatic logic [15:0] rand_op();
        int r;
        logic [15:0] sp [8] = '{16'h7F80, 16'hFF80, 16'h7FC0, 16'h0000, 16'h8000, 16'h0001, 16'h7F7F, 16'h0080};
        r = $urandom_range(0, 99);
        if (r < 3) return sp[$urandom_range(0, 7)];
        if (r < 8) return 16'($urandom);
        return {1'($urandom), 8'($urandom_range(118, 136)), 7'($urandom)};
    endfunction

`ifdef MUL_TREE_STATUS_EN
    task automatic status_case(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] want);
        logic [N*16-1:0] ops;
        status_clr = 1'b1;
        idle(1);
        status_clr = 1'b0;
        chk({name, "_clr"}, 64'(status), 64'h0);
        for (int i = 0; i < N; i++) ops[i*16 +: 16] = 16'h3F80;
        ops[15:0]  = a;
        ops[31:16] = b;
        send(ops, 1, 1'b1);
        idle(LOG2N + 2);
        chk({name, "_flags"}, 64'(status), 64'(want));
    endtask
`endif

    logic [N*16-1:0] vec;
    logic [N*16-1:0] m_res;
    logic [N-1:0]    m_stb;
    logic [3:0]      m_fl;

    initial begin
        logic [15:0] base [8] = '{16'h4000, 16'h3F00, 16'h4040, 16'h3F80,
                                  16'h4000, 16'h4000, 16'h3F00, 16'h3F80};
        for (int i = 0; i < N; i++) vec[i*16 +: 16] = base[i % 8];

        // Pin the reference model with hand-computed values.
        chk("ref_ovf",   64'(ref_mul(16'h7F00, 16'h4000)), 64'h47F80);
        chk("ref_inv",   64'(ref_mul(16'h7F80, 16'h0000)), 64'h87FC0);
        chk("ref_unf",   64'(ref_mul(16'h0080, 16'h3F00)), 64'h20000);
        chk("ref_daz",   64'(ref_mul(16'h0001, 16'h4000)), 64'h00000);
        chk("ref_rnd",   64'(ref_mul(16'h3F81, 16'h3F81)), 64'h13F82);
        chk("ref_tie_up", 64'(ref_mul(16'h3FC0, 16'h3F81)), 64'h13FC2);
        chk("ref_tie_ev", 64'(ref_mul(16'h3FC0, 16'h3F83)), 64'h13FC4);
        chk("ref_inf_fin", 64'(ref_mul(16'hFF80, 16'h4000)), 64'h0FF80);
        tree_model(vec, 3, m_res, m_stb, m_fl);
        chk("tree_m3_lanes", m_res[63:0], 64'h0000_0000_40C0_40C0);
        chk("tree_m3_stb", 64'(m_stb), 64'h0003);
        tree_model(vec, 1, m_res, m_stb, m_fl);
        chk("tree_m1_lanes", m_res[63:0], 64'h3F00_4080_4040_3F80);
        chk("tree_m1_stb", 64'(m_stb), 64'h00FF);

        repeat (3) @(posedge clk);
        #1;
`ifdef MUL_TREE_STATUS_EN
        chk("status_reset", 64'(status), 64'h0);
`endif
        // First strobe is presented in the same cycle reset deasserts.
        rst = 1'b0;
        send(vec, 3, 1'b1);
        send(vec, 1, 1'b1);
        send(vec, 0, 1'b1);
        send(vec, 7, 1'b1);
        send(vec, 4, 1'b1);
        send(vec, 2, 1'b0);
        send(vec, 5, 1'b1);
        idle(LOG2N + 2);

`ifdef MUL_TREE_STATUS_EN
        status_case("st_ovf", 16'h7F00, 16'h4000, 4'b0100);
        status_case("st_inv", 16'h7F80, 16'h0000, 4'b1000);
        status_case("st_unf", 16'h0080, 16'h3F00, 4'b0010);
        status_case("st_daz", 16'h0001, 16'h4000, 4'b0000);
`else
        for (int c = 0; c < 4; c++) begin
            logic [N*16-1:0] ops;
            logic [15:0] pa [4] = '{16'h7F00, 16'h7F80, 16'h0080, 16'h0001};
            logic [15:0] pb [4] = '{16'h4000, 16'h0000, 16'h3F00, 16'h4000};
            for (int i = 0; i < N; i++) ops[i*16 +: 16] = 16'h3F80;
            ops[15:0]  = pa[c];
            ops[31:16] = pb[c];
            send(ops, 1, 1'b1);
        end
        idle(LOG2N + 2);
`endif

        // Reset one cycle after a strobe: that transaction must never appear.
        send(vec, 3, 1'b1);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(LOG2N + 3);

        for (int t = 0; t < 10000; ) begin
            logic [N*16-1:0] ops;
            logic s;
            for (int i = 0; i < N; i++) ops[i*16 +: 16] = rand_op();
            s = ($urandom_range(0, 99) < 85);
            send(ops, int'($urandom_range(0, 7)), s);
            if (s) t++;
        end
        idle(LOG2N + 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
